// File: rtl/mux8_scan_ctrl.sv
// ---------------------------------------------------------------------------
// mux8_scan_ctrl
//   Upstream sequencer and capture stage for an NCH:1 mux. Steps the mux
//   select through channels 0..NCH-1, holding each channel for SETTLE cycles,
//   samples the mux output y at the end of each window, and assembles the
//   samples into an NCH-bit word that is offered downstream on valid/ready.
//   Single-shot (start) and free-running (continuous) scans are supported.
//
// Optional feature macro: SCAN_PARITY_EN
//   When defined, adds output 'parity' = XOR of the published word, loaded
//   on the same edge as data. When undefined the port and register are absent.
//
// Parameters
//   NCH     number of mux channels (power of 2, >= 2)
//   SETTLE  cycles each channel is held before y is sampled (>= 1)
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   begin a scan (honoured in IDLE only)
//   continuous  in   restart at channel 0 after each word (sampled at word end)
//   sel         out  mux select, straight from a register
//   y           in   mux output
//   busy        out  high while scanning
//   data        out  captured word; bit k = y sampled while sel==k
//   valid       out  data holds a word not yet accepted
//   ready       in   downstream accepts data when valid && ready at an edge
//   overrun     out  one-cycle pulse: a completed word was dropped
//   parity      out  (SCAN_PARITY_EN only) XOR of data
// ---------------------------------------------------------------------------
module mux8_scan_ctrl #(
  parameter  int NCH    = 8,
  parameter  int SETTLE = 1,
  localparam int SELW   = $clog2(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            continuous,
  output logic [SELW-1:0] sel,
  input  logic            y,
  output logic            busy,
  output logic [NCH-1:0]  data,
  output logic            valid,
  input  logic            ready,
  output logic            overrun
`ifdef SCAN_PARITY_EN
  ,
  output logic            parity
`endif
);

  // Window counter needs at least one bit even when SETTLE == 1.
  localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [WCW-1:0]  WCNT_LAST = WCW'(SETTLE - 1);
  localparam logic [SELW-1:0] SEL_LAST  = SELW'(NCH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [NCH-1:0]  shadow_q, shadow_d;
  logic [NCH-1:0]  data_q, data_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            overrun_q, overrun_d;
  logic [NCH-1:0]  word;
`ifdef SCAN_PARITY_EN
  logic            parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      wcnt_q    <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
`ifdef SCAN_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      wcnt_q    <= wcnt_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
`ifdef SCAN_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    wcnt_d    = wcnt_q;
    shadow_d  = shadow_q;
    data_d    = data_q;
    valid_d   = valid_q;
    busy_d    = busy_q;
    overrun_d = 1'b0;
`ifdef SCAN_PARITY_EN
    parity_d  = parity_q;
`endif
    // The last channel's sample goes straight into the published word,
    // since it is taken on the same edge the word completes.
    word          = shadow_q;
    word[NCH-1]   = y;

    // Plain transfer; a completion on the same edge overrides this below.
    if (valid_q && ready) begin
      valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          sel_d   = '0;
          wcnt_d  = '0;
          busy_d  = 1'b1;
        end
      end
      SCAN: begin
        if (wcnt_q != WCNT_LAST) begin
          wcnt_d = wcnt_q + 1'b1;
        end else begin
          shadow_d[sel_q] = y;
          wcnt_d          = '0;
          if (sel_q != SEL_LAST) begin
            sel_d = sel_q + 1'b1;
          end else begin
            sel_d = '0;
            if (!continuous) begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
            // Publish when the output slot is empty or being drained now.
            if (!valid_q || ready) begin
              data_d  = word;
              valid_d = 1'b1;
`ifdef SCAN_PARITY_EN
              parity_d = ^word;
`endif
            end else begin
              overrun_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sel     = sel_q;
  assign busy    = busy_q;
  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;
`ifdef SCAN_PARITY_EN
  assign parity  = parity_q;
`endif

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mux8_scan_ctrl
//   Directed and randomized checks for mux8_scan_ctrl. The 8:1 mux is modelled
//   behaviourally (y = pattern[sel]). Two instances: SETTLE=1 and SETTLE=3.
//   Parity checks are compiled in when SCAN_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_mux8_scan_ctrl;
  localparam int NCH = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  // SETTLE = 1 instance
  logic       start, continuous, ready, y, busy, valid, overrun;
  logic [2:0] sel;
  logic [7:0] data, a;
  // SETTLE = 3 instance
  logic       start3, cont3, ready3, y3, busy3, valid3, ovr3;
  logic [2:0] sel3;
  logic [7:0] data3, a3;
`ifdef SCAN_PARITY_EN
  logic       par, par3;
`endif

  // Behavioural 8:1 mux feeding each instance.
  assign y  = a[sel];
  assign y3 = a3[sel3];

  mux8_scan_ctrl #(.NCH(8), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous),
    .sel(sel), .y(y), .busy(busy), .data(data), .valid(valid),
    .ready(ready), .overrun(overrun)
`ifdef SCAN_PARITY_EN
    , .parity(par)
`endif
  );

  mux8_scan_ctrl #(.NCH(8), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .continuous(cont3),
    .sel(sel3), .y(y3), .busy(busy3), .data(data3), .valid(valid3),
    .ready(ready3), .overrun(ovr3)
`ifdef SCAN_PARITY_EN
    , .parity(par3)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Transaction-level model of the output slot.
  logic       mv;
  logic [7:0] md;
  logic       mov;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Channel on sel after 'edges' clock edges since the start edge.
  function automatic int exp_sel(input int edges, input int settle);
    return (edges / settle) % NCH;
  endfunction

  // One edge of the output slot: completion publishes if slot free or draining.
  task automatic model_step(input bit complete, input bit rdy);
    mov = 1'b0;
    if (complete) begin
      if (!mv || rdy) begin
        mv = 1'b1;
        md = a;
      end else begin
        mov = 1'b1;
      end
    end else if (mv && rdy) begin
      mv = 1'b0;
    end
  endtask

  task automatic scan1(input logic [7:0] pat);
    a     = pat;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (NCH) tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; continuous = 1'b0; ready = 1'b0; a = '0;
    start3 = 1'b0; cont3 = 1'b0; ready3 = 1'b0; a3 = '0;
    mv = 1'b0; md = '0; mov = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    chk("rst_sel", sel, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_data", data, 0);
    chk("rst_overrun", overrun, 0);

    // 1: asynchronous reset in the middle of a scan
    a = 8'hFF; start = 1'b1; tick(); start = 1'b0;
    tick(); tick();
    chk("mid_busy", busy, 1);
    chk("mid_sel", sel, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_sel", sel, 0);
    chk("async_busy", busy, 0);
    chk("async_valid", valid, 0);
    chk("async_data", data, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (12) tick();
    chk("postrst_valid", valid, 0);
    chk("postrst_busy", busy, 0);

    // 2: single scan with ready high
    a = 8'hA5; ready = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      chk("s2_sel", sel, exp_sel(k, 1));
      chk("s2_valid_low", valid, 0);
      chk("s2_overrun", overrun, 0);
      tick();
    end
    chk("s2_valid", valid, 1);
    chk("s2_data", data, 8'hA5);
    chk("s2_busy", busy, 0);
    chk("s2_overrun_end", overrun, 0);
    tick();
    chk("s2_drain", valid, 0);

`ifdef SCAN_PARITY_EN
    // 6: parity follows the published word
    ready = 1'b0;
    scan1(8'h07);
    chk("par07_data", data, 8'h07);
    chk("par07", par, 1);
    ready = 1'b1; tick(); ready = 1'b0;
    scan1(8'h03);
    chk("par03_data", data, 8'h03);
    chk("par03", par, 0);
    ready = 1'b1; tick();
    chk("par_drain", valid, 0);
`endif

    // 3: backpressure holds data and valid
    ready = 1'b0;
    scan1(8'h5A);
    chk("bp_valid", valid, 1);
    chk("bp_data", data, 8'h5A);
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_hold_valid", valid, 1);
      chk("bp_hold_data", data, 8'h5A);
    end
    ready = 1'b1;
    tick();
    chk("bp_release", valid, 0);

    // 4: continuous mode with overrun, then transfer+reload on one edge
    ready = 1'b0; continuous = 1'b1; a = 8'h3C; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
    chk("ov_w1_valid", valid, 1);
    chk("ov_w1_data", data, 8'h3C);
    chk("ov_w1_busy", busy, 1);
    a = 8'hC3;
    repeat (7) tick();
    chk("ov_pre", overrun, 0);
    tick();
    chk("ov_pulse", overrun, 1);
    chk("ov_keep_data", data, 8'h3C);
    chk("ov_keep_valid", valid, 1);
    tick();
    chk("ov_pulse_end", overrun, 0);
    chk("ov_keep_data2", data, 8'h3C);
    repeat (6) tick();
    ready = 1'b1; continuous = 1'b0;
    tick();
    chk("ov_reload_valid", valid, 1);
    chk("ov_reload_data", data, 8'hC3);
    chk("ov_reload_busy", busy, 0);
    chk("ov_reload_ovr", overrun, 0);
    tick();
    chk("ov_drain", valid, 0);

    // 5: SETTLE = 3, start pulses while busy ignored
    a3 = 8'h81; start3 = 1'b1;
    tick();
    start3 = 1'b0;
    for (int k = 0; k < 3 * NCH; k++) begin
      if (k == 10) start3 = 1'b1;
      if (k == 11) start3 = 1'b0;
      chk("st3_sel", sel3, exp_sel(k, 3));
      chk("st3_busy", busy3, 1);
      chk("st3_valid_low", valid3, 0);
      tick();
    end
    chk("st3_valid", valid3, 1);
    chk("st3_data", data3, 8'h81);
    chk("st3_busy_end", busy3, 0);
    chk("st3_ovr", ovr3, 0);

    // Randomized single-shot scans with random ready against the slot model
    ready = 1'b0; continuous = 1'b0;
    mv = 1'b0; md = 8'hC3; mov = 1'b0;
    for (int it = 0; it < 25; it++) begin
      int gap;
      bit r;
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        r = 1'($urandom_range(0, 1));
        ready = r;
        tick();
        model_step(1'b0, r);
        chk("rnd_idle_valid", valid, mv);
        chk("rnd_idle_busy", busy, 0);
      end
      a = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      ready = r; start = 1'b1;
      tick();
      start = 1'b0;
      model_step(1'b0, r);
      chk("rnd_start_busy", busy, 1);
      chk("rnd_start_sel", sel, 0);
      for (int k = 1; k <= NCH; k++) begin
        r = 1'($urandom_range(0, 1));
        ready = r;
        tick();
        model_step(k == NCH, r);
        chk("rnd_valid", valid, mv);
        chk("rnd_data", data, md);
        chk("rnd_overrun", overrun, mov);
        chk("rnd_busy", busy, (k < NCH) ? 1 : 0);
        chk("rnd_sel", sel, exp_sel(k, 1));
`ifdef SCAN_PARITY_EN
        chk("rnd_parity", par, ^md);
`endif
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
